alu_accum_mc: RTL and testbench
===============================

# alu_accum_mc

Parametrised, handshaked successor of the lab accumulator-ALU. Holds a 2·WIDTH-bit result register whose low WIDTH bits act as operand B, and applies one of eight functions with input Data as operand A. Single-cycle operations complete on the accepting edge. Multiply is a WIDTH-cycle iterative shift-add unit with Busy/Done signalling, so the block can sit behind a simple controller or a board-level switch/key front end.

## Interface
- WIDTH, 4, operand width; result register is 2·WIDTH bits; WIDTH ≥ 2
- Clock  in  1  rising-edge clock
- Reset_b  in  1  asynchronous, active-low reset
- Data  in  WIDTH  operand A
- Function  in  3  operation select, sampled only when an op is accepted
- Start  in  1  request; op accepted on a rising edge where Start=1 and Busy=0
- Busy  out  1  high while a multiply is in progress
- Done  out  1  high for the cycle following each op completion
- ALUout  out  2·WIDTH  result register; B = ALUout[WIDTH-1:0]

## Operation
- Reset (Reset_b=0, no clock needed): ALUout=0, Busy=0, Done=0, FSM=IDLE, internal multiply registers cleared.
- Start is ignored while Busy=1. Start=0 in IDLE leaves ALUout unchanged and Done=0.
- Functions; all results are computed at full width and then zero/sign-extended to 2·WIDTH:
  - 000 ADD: zero-extend(A + B) as a (WIDTH+1)-bit value; the carry lands in bit WIDTH.
  - 001 SUB: A − B as a (WIDTH+1)-bit two's-complement value, sign-extended to 2·WIDTH.
  - 010 SEXT: sign-extend B (bit WIDTH-1) to 2·WIDTH.
  - 011 ORR: ALUout = {0…, |{A,B}}.
  - 100 ANDR: ALUout = {0…, &{A,B}}.
  - 101 SHL: B zero-extended to 2·WIDTH, shifted left by A. If A ≥ 2·WIDTH the result is 0.
  - 110 MUL: unsigned A·B, computed iteratively (see FSM).
  - 111 HOLD: ALUout unchanged; still counts as a completed op, so Done pulses.
- FSM states: IDLE, MUL.
  - IDLE: if Start is accepted with Function≠110, write the result and stay in IDLE.
  - IDLE: if Start is accepted with Function=110, latch A and B into internal registers, clear the partial product, set the counter to 0, raise Busy, and go to MUL.
  - MUL: each edge, if multiplier bit[count]=1, add (multiplicand << count) to the partial product, then increment count.
  - MUL: on the edge where count = WIDTH−1, write the final product to ALUout, drop Busy, and return to IDLE.
- ALUout holds its previous value for the whole multiply; intermediate partial products are never visible.
- Data and Function changes during MUL have no effect, because the operands are latched.

## Timing
- Single-cycle op accepted at edge k: ALUout is updated at edge k, and Done=1 during cycle k→k+1.
- Start held high with single-cycle ops: one op per edge, Done stays high continuously.
- MUL accepted at edge k:
  - Busy=1 from edge k to edge k+WIDTH.
  - ALUout = product at edge k+WIDTH, with Busy=0 and Done=1 during cycle k+WIDTH→k+WIDTH+1.
  - The earliest next accept is edge k+WIDTH+1.
- Done is a registered output and is 0 in every other cycle.
- Reset asserted mid-multiply: the op is aborted immediately and asynchronously. All outputs go to 0, and the op does not resume after Reset_b is released.
- Reset released: the first accept is possible on the first rising edge where Reset_b=1.

## Test plan (WIDTH=4)
- Reset, then hold Start=0 for 5 cycles -> ALUout=8'h00, Busy=0, Done=0 throughout.
- ADD Data=F -> ALUout=8'h0F, Done pulse. Then ADD Data=1 -> ALUout=8'h10 (carry in bit 4).
- ADD Data=3 from 0, then SUB Data=1 -> 8'hFE. Then SEXT with B=8 (reach it via reset, ADD Data=8) -> 8'hF8.
- B=F, SHL Data=3 -> 8'h78. Then from B=F, SHL Data=8 -> 8'h00. Then ORR Data=0 with B=0 -> 8'h00; ANDR with A=F, B=F -> 8'h01.
- B=F, MUL Data=F:
  - Busy high for exactly 4 cycles.
  - ALUout stays 8'h0F, then becomes 8'hE1 on the 4th edge, with a single Done pulse.
  - Start with ADD pulsed during Busy is ignored.
- Begin MUL, drop Reset_b between edges in cycle 2 -> ALUout=0 and Busy=0 without a clock edge. After release: no Done pulse, ALUout stays 0.

Source files
------------

// File: rtl/alu_accum_mc_if.sv
// Request/response bundle for the accumulator ALU: operand, op select and
// start toward the block; busy/done status and the result register back.
interface alu_accum_mc_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   Data;
  logic [2:0]         Function;
  logic               Start;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] ALUout;

  modport master (
    output Data, Function, Start,
    input  Busy, Done, ALUout
  );

  modport slave (
    input  Data, Function, Start,
    output Busy, Done, ALUout
  );
endinterface

// File: rtl/alu_accum_mc.sv
// Handshaked accumulator ALU. The 2*WIDTH result register doubles as operand
// B (low half). Single-cycle ops retire on the accepting edge; multiply runs
// as a WIDTH-cycle shift-add sequence with Busy held for its duration.
module alu_accum_mc #(
  parameter int WIDTH = 4
) (
  input  logic          Clock,
  input  logic          Reset_b,
  alu_accum_mc_if.slave bus
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    F_ADD  = 3'b000,
    F_SUB  = 3'b001,
    F_SEXT = 3'b010,
    F_ORR  = 3'b011,
    F_ANDR = 3'b100,
    F_SHL  = 3'b101,
    F_MUL  = 3'b110,
    F_HOLD = 3'b111
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e          state, state_nxt;
  logic [RW-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [RW-1:0]   pp, pp_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            done, done_nxt;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum, diff;
  logic [RW-1:0]    shl_src;
  logic [RW-1:0]    op_res;
  logic [RW-1:0]    pp_step;

  assign a       = bus.Data;
  assign b       = acc[WIDTH-1:0];
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign shl_src = {{WIDTH{1'b0}}, b};

  // Single-cycle function results, all widened to the result register.
  always_comb begin
    op_res = acc;
    case (func_e'(bus.Function))
      F_ADD:  op_res = {{(WIDTH-1){1'b0}}, sum};
      F_SUB:  op_res = {{(WIDTH-1){diff[WIDTH]}}, diff};
      F_SEXT: op_res = {{WIDTH{b[WIDTH-1]}}, b};
      F_ORR:  op_res = {{(RW-1){1'b0}}, |{a, b}};
      F_ANDR: op_res = {{(RW-1){1'b0}}, &{a, b}};
      // Shift amounts past the register width flush everything out.
      F_SHL:  op_res = (32'(a) >= 32'(RW)) ? '0 : (shl_src << a);
      default: op_res = acc;
    endcase
  end

  // Next partial product: add the shifted multiplicand when this multiplier
  // bit is set.
  always_comb begin
    pp_step = pp;
    if (mplier[cnt])
      pp_step = pp + ({{WIDTH{1'b0}}, mcand} << cnt);
  end

  // Next-state and datapath update for the IDLE/MUL controller.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    pp_nxt     = pp;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          if (func_e'(bus.Function) == F_MUL) begin
            // Operands are captured so later Data changes cannot disturb
            // the product; ALUout keeps its old value until the end.
            mcand_nxt  = a;
            mplier_nxt = b;
            pp_nxt     = '0;
            cnt_nxt    = '0;
            state_nxt  = MUL;
          end else begin
            acc_nxt  = op_res;
            done_nxt = 1'b1;
          end
        end
      end
      MUL: begin
        pp_nxt  = pp_step;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          acc_nxt   = pp_step;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      pp     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      pp     <= pp_nxt;
      cnt    <= cnt_nxt;
      done   <= done_nxt;
    end
  end

  assign bus.Busy   = (state == MUL);
  assign bus.Done   = done;
  assign bus.ALUout = acc;

endmodule

// File: tb/tb_alu_accum_mc.sv
// Directed bench for alu_accum_mc at WIDTH=4: table of single-cycle ops plus
// hand sequences for back-to-back ops, multiply and reset during multiply.
module tb_alu_accum_mc;

  localparam int W = 4;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] SEXT = 3'b010;
  localparam logic [2:0] ORR  = 3'b011;
  localparam logic [2:0] ANDR = 3'b100;
  localparam logic [2:0] SHL  = 3'b101;
  localparam logic [2:0] MULF = 3'b110;
  localparam logic [2:0] HOLD = 3'b111;

  logic Clock = 1'b0;
  logic Reset_b = 1'b0;

  alu_accum_mc_if #(.WIDTH(W)) bus ();

  alu_accum_mc #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus.slave)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] fn;
    logic [3:0] data;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t v [NV];

  initial begin
    v[0]  = '{1'b1, ADD,  4'hF, 8'h0F};
    v[1]  = '{1'b0, ADD,  4'h1, 8'h10};  // carry into bit 4
    v[2]  = '{1'b1, ADD,  4'h3, 8'h03};
    v[3]  = '{1'b0, SUB,  4'h1, 8'hFE};  // 1-3 = -2
    v[4]  = '{1'b1, ADD,  4'h8, 8'h08};
    v[5]  = '{1'b0, SEXT, 4'h0, 8'hF8};
    v[6]  = '{1'b1, ADD,  4'hF, 8'h0F};
    v[7]  = '{1'b0, SHL,  4'h3, 8'h78};
    v[8]  = '{1'b1, ADD,  4'hF, 8'h0F};
    v[9]  = '{1'b0, SHL,  4'h8, 8'h00};  // shift >= 8 flushes
    v[10] = '{1'b1, ORR,  4'h0, 8'h00};
    v[11] = '{1'b1, ADD,  4'hF, 8'h0F};
    v[12] = '{1'b0, ANDR, 4'hF, 8'h01};
    v[13] = '{1'b1, ADD,  4'h5, 8'h05};
    v[14] = '{1'b0, HOLD, 4'hA, 8'h05};  // unchanged, still Done
    v[15] = '{1'b0, SUB,  4'h7, 8'h02};  // 7-5 = 2

    bus.Start = 1'b0;
    bus.Function = ADD;
    bus.Data = '0;

    // Reset state, checked without any clock edge
    #2;
    chk("rst_alu", 32'(bus.ALUout), 32'h00);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    @(negedge Clock);
    Reset_b = 1'b1;

    // Idle for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      chk("idle_alu", 32'(bus.ALUout), 32'h00);
      chk("idle_busy", 32'(bus.Busy), 32'h0);
      chk("idle_done", 32'(bus.Done), 32'h0);
    end

    // Table of single-cycle ops
    for (int i = 0; i < NV; i++) begin
      @(negedge Clock);
      if (v[i].rst) begin
        Reset_b = 1'b0;
        #2;
        Reset_b = 1'b1;
      end
      bus.Start = 1'b1;
      bus.Function = v[i].fn;
      bus.Data = v[i].data;
      @(posedge Clock); #1;
      chk($sformatf("vec%0d_alu", i), 32'(bus.ALUout), 32'(v[i].exp));
      chk($sformatf("vec%0d_done", i), 32'(bus.Done), 32'h1);
      chk($sformatf("vec%0d_busy", i), 32'(bus.Busy), 32'h0);
      @(negedge Clock);
      bus.Start = 1'b0;
      bus.Data = 4'hC;
      @(posedge Clock); #1;
      chk($sformatf("vec%0d_idle_done", i), 32'(bus.Done), 32'h0);
      chk($sformatf("vec%0d_idle_alu", i), 32'(bus.ALUout), 32'(v[i].exp));
    end

    // Start held high: one op per edge, Done stays high
    @(negedge Clock);
    Reset_b = 1'b0;
    #2;
    Reset_b = 1'b1;
    bus.Start = 1'b1;
    bus.Function = ADD;
    bus.Data = 4'h1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge Clock); #1;
      chk("b2b_alu", 32'(bus.ALUout), 32'(i));
      chk("b2b_done", 32'(bus.Done), 32'h1);
    end
    @(negedge Clock);
    bus.Start = 1'b0;

    // Multiply F*F = E1
    @(negedge Clock);
    Reset_b = 1'b0;
    #2;
    Reset_b = 1'b1;
    bus.Start = 1'b1;
    bus.Function = ADD;
    bus.Data = 4'hF;
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.Function = MULF;
    bus.Data = 4'hF;
    @(posedge Clock); #1;
    chk("mul_busy0", 32'(bus.Busy), 32'h1);
    chk("mul_alu0", 32'(bus.ALUout), 32'h0F);
    chk("mul_done0", 32'(bus.Done), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clock);
      if (i == 2) begin
        // ADD request during Busy must be ignored
        bus.Start = 1'b1;
        bus.Function = ADD;
        bus.Data = 4'h1;
      end else begin
        bus.Start = 1'b0;
        bus.Function = SUB;
        bus.Data = 4'h3;
      end
      @(posedge Clock); #1;
      if (i < 4) begin
        chk($sformatf("mul_busy%0d", i), 32'(bus.Busy), 32'h1);
        chk($sformatf("mul_alu%0d", i), 32'(bus.ALUout), 32'h0F);
        chk($sformatf("mul_done%0d", i), 32'(bus.Done), 32'h0);
      end else begin
        chk("mul_busy_end", 32'(bus.Busy), 32'h0);
        chk("mul_alu_end", 32'(bus.ALUout), 32'hE1);
        chk("mul_done_end", 32'(bus.Done), 32'h1);
      end
    end
    @(posedge Clock); #1;
    chk("mul_after_done", 32'(bus.Done), 32'h0);
    chk("mul_after_alu", 32'(bus.ALUout), 32'hE1);

    // Reset during multiply
    @(negedge Clock);
    Reset_b = 1'b0;
    #2;
    Reset_b = 1'b1;
    bus.Start = 1'b1;
    bus.Function = ADD;
    bus.Data = 4'hF;
    @(negedge Clock);
    bus.Function = MULF;
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    @(posedge Clock); #1;
    chk("rmul_busy", 32'(bus.Busy), 32'h1);
    #1;
    Reset_b = 1'b0;
    #1;
    chk("rmul_async_alu", 32'(bus.ALUout), 32'h00);
    chk("rmul_async_busy", 32'(bus.Busy), 32'h0);
    chk("rmul_async_done", 32'(bus.Done), 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    Reset_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      chk("rmul_post_done", 32'(bus.Done), 32'h0);
      chk("rmul_post_alu", 32'(bus.ALUout), 32'h00);
      chk("rmul_post_busy", 32'(bus.Busy), 32'h0);
    end

    // First accept on the first edge after release
    @(negedge Clock);
    Reset_b = 1'b0;
    #1;
    Reset_b = 1'b1;
    bus.Start = 1'b1;
    bus.Function = ADD;
    bus.Data = 4'h3;
    @(posedge Clock); #1;
    chk("first_accept_alu", 32'(bus.ALUout), 32'h03);
    chk("first_accept_done", 32'(bus.Done), 32'h1);
    @(negedge Clock);
    bus.Start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
